// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a valid/ready handshake.
// Optional line break is enabled by defining UART_TX_BREAK_EN, which adds the i_break port.
module uart_tx_frame #(
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int TIMER_BITS      = 32,
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic [3:0]           o_bit_idx,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_break,
`endif
  output logic                 uart_rxd_out
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLOCKS_PER_BAUD < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLOCKS_PER_BAUD must be >= 2");
  end

  localparam logic [TIMER_BITS-1:0] RELOAD   = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [3:0]            IDX_IDLE = 4'd15;
  localparam logic [3:0]            IDX_DLAST = 4'(DATA_BITS);
  localparam logic [3:0]            IDX_LAST =
    4'(DATA_BITS + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q;
  logic [TIMER_BITS-1:0]  cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic [3:0]             idx_q;
  logic                   line_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   brk;

`ifdef UART_TX_BREAK_EN
  assign brk = i_break;
`else
  assign brk = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= IDX_IDLE;
      line_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Break has priority over a pending word.
          if (brk) begin
            state_q <= S_BREAK;
            line_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (i_valid) begin
            state_q <= S_START;
            shift_q <= i_data;
            par_q   <= (^i_data) ^ (PARITY_MODE == 1);
            cnt_q   <= RELOAD;
            idx_q   <= 4'd0;
            line_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_BREAK: begin
          if (!brk) begin
            state_q <= S_IDLE;
            line_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - TIMER_BITS'(1);
          end else begin
            cnt_q <= RELOAD;
            idx_q <= idx_q + 4'd1;
            case (state_q)
              S_START: begin
                state_q <= S_DATA;
                line_q  <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
              S_DATA: begin
                if (idx_q == IDX_DLAST) begin
                  state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                  line_q  <= (PARITY_MODE != 0) ? par_q : 1'b1;
                end else begin
                  line_q  <= shift_q[0];
                  shift_q <= shift_q >> 1;
                end
              end
              S_PARITY: begin
                state_q <= S_STOP;
                line_q  <= 1'b1;
              end
              default: begin
                line_q <= 1'b1;
                if (idx_q == IDX_LAST) begin
                  state_q <= S_IDLE;
                  idx_q   <= IDX_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_busy       = busy_q;
  assign o_bit_idx    = idx_q;
  assign uart_rxd_out = line_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter sets, a slot-arithmetic reference model checked every
// cycle, hand-computed frame checks, mid-frame async reset, random traffic and (if enabled) break.
module tb_uart_tx_frame;

  localparam int NI = 4;
  localparam int DB  [NI] = '{8, 8, 8, 7};
  localparam int PM  [NI] = '{0, 2, 1, 0};
  localparam int SB  [NI] = '{1, 1, 1, 2};
  localparam int CPB [NI] = '{4, 4, 4, 3};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [NI];
  logic [8:0] data  [NI];
  logic       rdy   [NI];
  logic       bsy   [NI];
  logic       line  [NI];
  logic [3:0] idx   [NI];
`ifdef UART_TX_BREAK_EN
  logic       brk   [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_frame #(
      .DATA_BITS(DB[g]), .PARITY_MODE(PM[g]), .STOP_BITS(SB[g]),
      .TIMER_BITS(16), .CLOCKS_PER_BAUD(CPB[g])
    ) u_dut (
      .clk(clk),
      .i_reset_n(rst_n),
      .i_valid(valid[g]),
      .i_data(data[g][DB[g]-1:0]),
      .o_ready(rdy[g]),
      .o_busy(bsy[g]),
      .o_bit_idx(idx[g]),
`ifdef UART_TX_BREAK_EN
      .i_break(brk[g]),
`endif
      .uart_rxd_out(line[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: el = cycles since the transfer edge, -1 idle, -2 break.
  int         el [NI];
  logic [8:0] wd [NI];

  function automatic int nslots(input int k);
    return 1 + DB[k] + ((PM[k] != 0) ? 1 : 0) + SB[k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) el[k] = -1;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (el[k] >= 0) begin
          el[k] = el[k] + 1;
          if (el[k] == nslots(k) * CPB[k]) el[k] = -1;
        end
`ifdef UART_TX_BREAK_EN
        else if (el[k] == -2) begin
          if (!brk[k]) el[k] = -1;
        end
        else if (brk[k]) el[k] = -2;
`endif
        else if (valid[k]) begin
          el[k] = 0;
          wd[k] = data[k] & ((9'h1 << DB[k]) - 9'h1);
        end
      end
    end
  end

  function automatic int exp_line(input int k);
    int s;
    if (el[k] == -1) return 1;
    if (el[k] == -2) return 0;
    s = el[k] / CPB[k];
    if (s == 0) return 0;
    if (s <= DB[k]) return int'(wd[k][s-1]);
    if (PM[k] != 0 && s == DB[k] + 1) return int'((^wd[k]) ^ (PM[k] == 1));
    return 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("sb_line%0d", k), int'(line[k]), exp_line(k));
        chk($sformatf("sb_ready%0d", k), int'(rdy[k]), (el[k] == -1) ? 1 : 0);
        chk($sformatf("sb_busy%0d", k), int'(bsy[k]), (el[k] == -1) ? 0 : 1);
        chk($sformatf("sb_idx%0d", k), int'(idx[k]), (el[k] < 0) ? 15 : el[k] / CPB[k]);
      end
    end
  end

  logic cap_line [0:127];
  logic cap_rdy  [0:127];
  int   cap_idx  [0:127];

  task automatic send(input int k, input logic [8:0] d);
    @(negedge clk);
    valid[k] = 1'b1;
    data[k]  = d;
    @(posedge clk);
  endtask

  task automatic capture(input int k, input int n, input int drop_at, input logic [8:0] nd);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_line[c] = line[k];
      cap_rdy[c]  = rdy[k];
      cap_idx[c]  = int'(idx[k]);
      if (c == 0) data[k] = nd;
      if (c == drop_at) valid[k] = 1'b0;
    end
  endtask

  initial begin
    int err;
    int cnt;
    logic [9:0] p55;
    p55 = 10'b1010101010;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      valid[k] = 1'b0;
      data[k]  = '0;
`ifdef UART_TX_BREAK_EN
      brk[k]   = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_line", int'(line[k]), 1);
      chk("rst_ready", int'(rdy[k]), 1);
      chk("rst_busy", int'(bsy[k]), 0);
      chk("rst_idx", int'(idx[k]), 15);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 CPB=4, 0x55
    send(0, 9'h055);
    capture(0, 41, 0, 9'h055);
    err = 0; cnt = 0;
    for (int c = 0; c < 40; c++) if (cap_line[c] != p55[c/4]) err++;
    for (int c = 0; c < 41; c++) if (!cap_rdy[c]) cnt++;
    chk("t1_line_pattern_errs", err, 0);
    chk("t1_ready_low_cycles", cnt, 40);
    chk("t1_idle_line", int'(cap_line[40]), 1);

    // parity slot checks
    send(1, 9'h0A5);
    capture(1, 45, 0, 9'h0A5);
    chk("t2_8e1_idx", cap_idx[36], 9);
    chk("t2_8e1_a5_par", int'(cap_line[37]), 0);
    chk("t2_8e1_stop_idx", cap_idx[40], 10);
    chk("t2_8e1_idle_idx", cap_idx[44], 15);
    send(2, 9'h0A5);
    capture(2, 45, 0, 9'h0A5);
    chk("t2_8o1_a5_par", int'(cap_line[37]), 1);
    send(1, 9'h007);
    capture(1, 45, 0, 9'h007);
    chk("t2_8e1_07_par", int'(cap_line[38]), 1);

    // 7N2 CPB=3, 0x7F
    send(3, 9'h07F);
    capture(3, 31, 0, 9'h07F);
    err = 0;
    for (int c = 0; c < 30; c++) if (cap_idx[c] != c / 3) err++;
    chk("t3_idx_errs", err, 0);
    chk("t3_idle_idx", cap_idx[30], 15);
    err = 0; cnt = 0;
    for (int c = 0; c < 30; c++) if (int'(cap_line[c]) != ((c < 3) ? 0 : 1)) err++;
    for (int c = 0; c < 31; c++) if (!cap_rdy[c]) cnt++;
    chk("t3_line_errs", err, 0);
    chk("t3_frame_len", cnt, 30);

    // back-to-back with valid held high
    send(0, 9'h001);
    capture(0, 82, 60, 9'h080);
    cnt = 0;
    for (int c = 0; c < 81; c++) if (cap_rdy[c]) cnt++;
    chk("t4_gap_cycles", cnt, 1);
    chk("t4_gap_line", int'(cap_line[40]), 1);
    chk("t4_gap_ready", int'(cap_rdy[40]), 1);
    chk("t4_f1_d0", int'(cap_line[4]), 1);
    chk("t4_f2_start", int'(cap_line[41]), 0);
    chk("t4_f2_d0", int'(cap_line[45]), 0);
    chk("t4_f2_d7", int'(cap_line[73]), 1);

    // async reset during data bit 3
    send(0, 9'h000);
    capture(0, 18, 0, 9'h000);
    chk("t5_idx_before", cap_idx[17], 4);
    chk("t5_line_before", int'(line[0]), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_line", int'(line[0]), 1);
    chk("t5_rst_idx", int'(idx[0]), 15);
    chk("t5_rst_ready", int'(rdy[0]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 9'h055);
    capture(0, 41, 0, 9'h055);
    err = 0;
    for (int c = 0; c < 40; c++) if (cap_line[c] != p55[c/4]) err++;
    chk("t5_clean_frame_errs", err, 0);
    chk("t5_clean_idx0", cap_idx[0], 0);

`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    brk[0] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!line[0] && !rdy[0]) cnt++;
      if (c == 19) brk[0] = 1'b0;
    end
    chk("t6_break_low_cycles", cnt, 20);
    @(negedge clk);
    chk("t6_break_release_line", int'(line[0]), 1);
    send(0, 9'h055);
    brk[0] = 1'b1;
    capture(0, 42, 0, 9'h055);
    chk("t6_mid_stop", int'(cap_line[39]), 1);
    chk("t6_mid_after", int'(cap_line[41]), 0);
    brk[0] = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        valid[k] = ($urandom_range(0, 3) == 0);
        data[k]  = 9'($urandom);
`ifdef UART_TX_BREAK_EN
        brk[k]   = ($urandom_range(0, 40) == 0) ? ~brk[k] : brk[k];
`endif
      end
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      valid[k] = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk[k]   = 1'b0;
`endif
    end
    repeat (60) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
